core_icache_controller: RTL and testbench
=========================================

Name: core_icache_controller

Overview:
- Control and AXI-refill side of the instruction cache. Holds the tag and valid arrays and checks every core fetch for a hit.
- On a miss it issues a single-beat AXI read for the missing 256-bit line. The R-channel data is wired directly to the icache data array's block input; this block drives that array's rd_en, wr_en, block_replace and offset strobes.
- Handles fetches that straddle two lines, cache flush, and AXI read errors.

Parameters:
- ADDR_WIDTH, 64, core/AXI address width
- INDEX_WIDTH, 7, line index bits [11:5] (128 lines)
- TAG_WIDTH, 52, tag bits [63:12]
- LINE_OFFSET_WIDTH, 5, byte offset within a 32-byte line

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  core fetch request valid
- i_addr_from_core  in  64  fetch byte address, 2-byte aligned; held stable by the core while o_stall=1
- i_flush  in  1  one-cycle pulse: invalidate all lines
- o_stall  out  1  fetch not served this cycle
- o_fetch_error  out  1  one-cycle pulse: fetch aborted on AXI error
- o_rd_en  out  1  data array read enable
- o_wr_en  out  1  data array write enable
- o_block_replace  out  1  data array line replace
- o_offset  out  1  0 = write the line of addr; 1 = write the line of addr+2
- o_araddr  out  64  AXI read address, line-aligned
- o_arvalid  out  1  AXI AR valid
- i_arready  in  1  AXI AR ready
- i_rvalid  in  1  AXI R valid
- i_rresp  in  2  AXI R response
- i_rlast  in  1  AXI R last; always 1 because bursts are single-beat
- o_rready  out  1  AXI R ready

Behaviour:
- Reset is asynchronous: all valid bits 0, FSM in IDLE, flush_pending 0, every output 0 (o_stall=0 while reset is asserted).
- Line addresses:
  - line0 = addr[63:5]
  - line1 = (addr+2)[63:5]
  - The fetch spans two lines iff addr[4:0]==30.
- Hit condition: valid[idx] && tag[idx]==addr tag, evaluated for line0 and line1. A fetch hits only if both lines hit.
- IDLE, i_req=1, hit, no flush pending:
  - o_rd_en=1 and o_stall=0 in the same cycle (combinational, 0-cycle hit latency).
- IDLE, i_req=1, miss:
  - o_stall=1 in the same cycle.
  - Latch the missing line (line0 has priority) into miss_line / miss_sel (0 = line0, 1 = line1).
  - Next state AR.
- AR state:
  - o_arvalid=1 and o_araddr={miss_line,5'b0}.
  - Address is held stable until i_arready.
  - On o_arvalid&&i_arready, go to RD.
- RD state:
  - o_rready=1.
  - On i_rvalid with i_rresp==2'b00: o_wr_en=1, o_block_replace=1, o_offset=miss_sel in that same cycle. Tag and valid for that line are written on that edge. Return to IDLE.
- Fetches that span two lines:
  - After the first line's refill, IDLE re-evaluates and line1 may miss. That triggers a second refill with o_offset=1.
- Error: i_rvalid with i_rresp!=0 in RD.
  - No data write, valid unchanged.
  - Next cycle, state ERR: o_fetch_error=1, o_stall=0, o_rd_en=0. Return to IDLE.
- o_stall=1 in AR, RD and ERR→? Exact values: o_stall=1 in AR and RD; o_stall=0 in ERR.
- Flush:
  - i_flush sets flush_pending.
  - In IDLE with flush_pending, all valid bits are cleared on the next edge and flush_pending clears. o_stall=1 during that cycle.
  - A flush arriving during AR/RD is applied after the refill completes, so the refilled line ends up invalid.
- Simultaneous i_flush and hit in IDLE: the flush wins (stall, invalidate).
- i_req=0 in IDLE: no lookup; o_stall=0, o_rd_en=0.
- Reset mid-refill: FSM returns to IDLE and o_arvalid/o_rready drop immediately. Any in-flight AXI response after reset is the interconnect's responsibility.
- Minimum miss penalty with arready and rvalid each arriving one cycle after being enabled: o_stall=1 for cycles 0–2, hit data at cycle 3.

Test Plan:
- Reset, then i_req=1 at addr 0x1000:
  - required: o_stall=1, o_araddr=0x1000, o_arvalid=1.
  - With arready=1 and rvalid=1/rresp=0: o_wr_en=o_block_replace=1, o_offset=0; next cycle o_stall=0, o_rd_en=1.
- Refetch 0x1004 after the refill above:
  - required: same-cycle hit, no AR issued.
- Cold fetch at 0x201E:
  - required: two refills, AR 0x2000 (o_offset=0) then AR 0x2020 (o_offset=1); hit after the second write.
- Fill addr 0x1000, then fetch 0x3000 (same index 0, different tag):
  - required: miss, AR 0x3000, line replaced.
  - A later fetch of 0x1000 misses again.
- Refill with rresp=2'b10:
  - required: o_wr_en stays 0, one-cycle o_fetch_error with o_stall=0.
  - The same address misses on retry.
- i_flush during RD of 0x4000:
  - required: the refill completes, then all valid bits are cleared.
  - A fetch of 0x4000 misses and AR is reissued.
- arready held low for 5 cycles:
  - required: o_arvalid and o_araddr stable, o_stall=1 throughout.

Source files
------------

// File: rtl/core_icache_controller.sv
// Instruction cache controller: tag/valid lookup, single-beat AXI line refill,
// line-straddling fetches, flush and AXI read-error handling.
module core_icache_controller #(
  parameter int ADDR_WIDTH        = 64,
  parameter int INDEX_WIDTH       = 7,
  parameter int TAG_WIDTH         = 52,
  parameter int LINE_OFFSET_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr_from_core,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_fetch_error,
  output logic                  o_rd_en,
  output logic                  o_wr_en,
  output logic                  o_block_replace,
  output logic                  o_offset,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic                  i_rvalid,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  output logic                  o_rready
);

  localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET_WIDTH;
  localparam int LINES  = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, AR, RD, ERR} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [LINES-1:0]        valid;
  logic [TAG_WIDTH-1:0]    tags [LINES];
  logic                    flush_pending;
  logic [LINE_W-1:0]       miss_line;
  logic                    miss_sel;

  logic [ADDR_WIDTH-1:0]   addr_p2;
  logic [LINE_W-1:0]       line0;
  logic [LINE_W-1:0]       line1;
  logic [INDEX_WIDTH-1:0]  idx0;
  logic [INDEX_WIDTH-1:0]  idx1;
  logic [INDEX_WIDTH-1:0]  miss_idx;
  logic                    hit0;
  logic                    hit1;

  logic                    flush_now;
  logic                    refill_we;
  logic                    miss_capture;
  logic                    stall;
  logic                    rd_en;
  logic                    fetch_error;
  logic                    arvalid;
  logic                    rready;
  logic                    unused_bits;

  // line1 equals line0 unless the fetch starts at byte 30 of a line
  assign addr_p2  = i_addr_from_core + ADDR_WIDTH'(2);
  assign line0    = i_addr_from_core[ADDR_WIDTH-1:LINE_OFFSET_WIDTH];
  assign line1    = addr_p2[ADDR_WIDTH-1:LINE_OFFSET_WIDTH];
  assign idx0     = line0[INDEX_WIDTH-1:0];
  assign idx1     = line1[INDEX_WIDTH-1:0];
  assign miss_idx = miss_line[INDEX_WIDTH-1:0];

  assign hit0 = valid[idx0] && (tags[idx0] == line0[INDEX_WIDTH +: TAG_WIDTH]);
  assign hit1 = valid[idx1] && (tags[idx1] == line1[INDEX_WIDTH +: TAG_WIDTH]);

  assign unused_bits = ^{i_rlast, addr_p2[LINE_OFFSET_WIDTH-1:0],
                         i_addr_from_core[LINE_OFFSET_WIDTH-1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    rd_en        = 1'b0;
    fetch_error  = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    o_wr_en         = 1'b0;
    o_block_replace = 1'b0;
    o_offset        = 1'b0;
    o_araddr        = '0;
    flush_now    = 1'b0;
    refill_we    = 1'b0;
    miss_capture = 1'b0;
    unique case (state)
      IDLE: begin
        // A pending or arriving flush takes priority over any lookup
        if (flush_pending || i_flush) begin
          stall     = 1'b1;
          flush_now = 1'b1;
        end else if (i_req) begin
          if (hit0 && hit1) begin
            rd_en = 1'b1;
          end else begin
            stall        = 1'b1;
            miss_capture = 1'b1;
            state_nxt    = AR;
          end
        end
      end
      AR: begin
        stall    = 1'b1;
        arvalid  = 1'b1;
        o_araddr = {miss_line, {LINE_OFFSET_WIDTH{1'b0}}};
        if (i_arready) state_nxt = RD;
      end
      RD: begin
        stall  = 1'b1;
        rready = 1'b1;
        if (i_rvalid) begin
          if (i_rresp == 2'b00) begin
            o_wr_en         = 1'b1;
            o_block_replace = 1'b1;
            o_offset        = miss_sel;
            refill_we       = 1'b1;
            state_nxt       = IDLE;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ERR: begin
        fetch_error = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall and hit read are suppressed while reset is held
  assign o_stall       = stall & i_rst_n;
  assign o_rd_en       = rd_en & i_rst_n;
  assign o_fetch_error = fetch_error;
  assign o_arvalid     = arvalid;
  assign o_rready      = rready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid         <= '0;
      flush_pending <= 1'b0;
    end else if (flush_now) begin
      valid         <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (refill_we) valid[miss_idx] <= 1'b1;
      if (i_flush)   flush_pending   <= 1'b1;
    end
  end

  // line0 is refilled first; line1 only once line0 already hits
  always_ff @(posedge i_clk) begin
    if (miss_capture) begin
      miss_line <= hit0 ? line1 : line0;
      miss_sel  <= hit0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (refill_we) tags[miss_idx] <= miss_line[INDEX_WIDTH +: TAG_WIDTH];
  end

endmodule

// File: tb/tb_core_icache_controller.sv
// Directed bench for core_icache_controller: hits, misses, straddling
// fetches, replacement, AXI errors, flush and AR back-pressure.
module tb_core_icache_controller;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req;
  logic [63:0] i_addr_from_core;
  logic        i_flush;
  logic        o_stall;
  logic        o_fetch_error;
  logic        o_rd_en;
  logic        o_wr_en;
  logic        o_block_replace;
  logic        o_offset;
  logic [63:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic        i_rvalid;
  logic [1:0]  i_rresp;
  logic        i_rlast;
  logic        o_rready;

  int errors = 0;
  int checks = 0;

  core_icache_controller dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_req            (i_req),
    .i_addr_from_core (i_addr_from_core),
    .i_flush          (i_flush),
    .o_stall          (o_stall),
    .o_fetch_error    (o_fetch_error),
    .o_rd_en          (o_rd_en),
    .o_wr_en          (o_wr_en),
    .o_block_replace  (o_block_replace),
    .o_offset         (o_offset),
    .o_araddr         (o_araddr),
    .o_arvalid        (o_arvalid),
    .i_arready        (i_arready),
    .i_rvalid         (i_rvalid),
    .i_rresp          (i_rresp),
    .i_rlast          (i_rlast),
    .o_rready         (o_rready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Entered in the IDLE miss cycle; leaves in the IDLE cycle after the write.
  task automatic refill(input string tag, input logic [63:0] exp_addr, input logic exp_off);
    chk({tag, "_miss_stall"}, o_stall, 1);
    tick();
    chk({tag, "_arvalid"}, o_arvalid, 1);
    chk({tag, "_araddr"}, o_araddr, exp_addr);
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_rvalid  = 1'b1;
    i_rresp   = 2'b00;
    #1;
    chk({tag, "_rready"}, o_rready, 1);
    chk({tag, "_wr_en"}, o_wr_en, 1);
    chk({tag, "_offset"}, o_offset, exp_off);
    tick();
    i_rvalid = 1'b0;
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req = 1'b1;
    i_addr_from_core = 64'h1000;
    i_flush = 1'b0;
    i_arready = 1'b0;
    i_rvalid = 1'b0;
    i_rresp = 2'b00;
    i_rlast = 1'b1;
    #1;
    chk("rst_stall", o_stall, 0);
    chk("rst_arvalid", o_arvalid, 0);
    chk("rst_rd_en", o_rd_en, 0);
    tick();
    tick();
    i_rst_n = 1'b1;
    #1;

    // Cold miss on 0x1000, minimum penalty
    chk("c1_stall", o_stall, 1);
    tick();
    chk("c1_arvalid", o_arvalid, 1);
    chk("c1_araddr", o_araddr, 64'h1000);
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    chk("c1_rready", o_rready, 1);
    chk("c1_rd_stall", o_stall, 1);
    i_rvalid = 1'b1;
    #1;
    chk("c1_wr_en", o_wr_en, 1);
    chk("c1_replace", o_block_replace, 1);
    chk("c1_offset", o_offset, 0);
    tick();
    i_rvalid = 1'b0;
    #1;
    chk("c1_hit_stall", o_stall, 0);
    chk("c1_hit_rd_en", o_rd_en, 1);

    // Refetch within the same line hits with no AR
    i_addr_from_core = 64'h1004;
    #1;
    chk("refetch_stall", o_stall, 0);
    chk("refetch_rd_en", o_rd_en, 1);
    tick();
    chk("refetch_no_ar", o_arvalid, 0);
    i_req = 1'b0;
    #1;
    chk("noreq_stall", o_stall, 0);
    chk("noreq_rd_en", o_rd_en, 0);
    i_req = 1'b1;

    // Fetch straddling 0x2000/0x2020
    i_addr_from_core = 64'h201E;
    #1;
    refill("span0", 64'h2000, 1'b0);
    refill("span1", 64'h2020, 1'b1);
    chk("span_hit_stall", o_stall, 0);
    chk("span_hit_rd_en", o_rd_en, 1);

    // Same index, different tag replaces the line
    i_addr_from_core = 64'h3000;
    #1;
    refill("repl", 64'h3000, 1'b0);
    chk("repl_hit", o_rd_en, 1);
    i_addr_from_core = 64'h1000;
    #1;
    chk("repl_old_miss", o_stall, 1);
    refill("refill1000", 64'h1000, 1'b0);

    // AXI read error
    i_addr_from_core = 64'h5000;
    #1;
    chk("err_miss", o_stall, 1);
    tick();
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_rvalid = 1'b1;
    i_rresp = 2'b10;
    #1;
    chk("err_no_wr", o_wr_en, 0);
    tick();
    i_rvalid = 1'b0;
    i_rresp = 2'b00;
    #1;
    chk("err_pulse", o_fetch_error, 1);
    chk("err_stall", o_stall, 0);
    chk("err_rd_en", o_rd_en, 0);
    tick();
    chk("err_pulse_gone", o_fetch_error, 0);
    refill("err_retry", 64'h5000, 1'b0);

    // Flush arriving during RD of 0x4000
    i_addr_from_core = 64'h4000;
    #1;
    chk("fl_miss", o_stall, 1);
    tick();
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_flush = 1'b1;
    #1;
    chk("fl_in_rd", o_rready, 1);
    tick();
    i_flush = 1'b0;
    i_rvalid = 1'b1;
    #1;
    chk("fl_refill_wr", o_wr_en, 1);
    tick();
    i_rvalid = 1'b0;
    #1;
    chk("fl_apply_stall", o_stall, 1);
    chk("fl_apply_rd_en", o_rd_en, 0);
    chk("fl_apply_no_ar", o_arvalid, 0);
    tick();
    chk("fl_after_miss", o_stall, 1);
    tick();
    chk("fl_reissue_ar", o_arvalid, 1);
    chk("fl_reissue_addr", o_araddr, 64'h4000);
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_rvalid = 1'b1;
    tick();
    i_rvalid = 1'b0;
    i_addr_from_core = 64'h1000;
    #1;
    chk("fl_old_invalid", o_stall, 1);

    // arready held low for 5 cycles
    i_addr_from_core = 64'h6000;
    #1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_arvalid", o_arvalid, 1);
      chk("bp_araddr", o_araddr, 64'h6000);
      chk("bp_stall", o_stall, 1);
      tick();
    end
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_rvalid = 1'b1;
    tick();
    i_rvalid = 1'b0;
    #1;
    chk("bp_hit", o_rd_en, 1);

    // Flush together with a hit: flush wins
    i_flush = 1'b1;
    #1;
    chk("flhit_stall", o_stall, 1);
    chk("flhit_rd_en", o_rd_en, 0);
    tick();
    i_flush = 1'b0;
    #1;
    chk("flhit_now_miss", o_stall, 1);
    tick();
    chk("flhit_ar", o_arvalid, 1);

    // Reset mid-refill drops AR immediately
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_arvalid", o_arvalid, 0);
    chk("rstmid_stall", o_stall, 0);
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("rstmid_miss", o_stall, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
